// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-access stage: word/register types, the
// write-back source select and the stage FSM encoding.
package cpu_types_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int REG_W      = 5;

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef logic [REG_W-1:0]      regbits_t;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'd0,
        MTR_LOAD = 2'd1,
        MTR_LUI  = 2'd2,
        MTR_PCP4 = 2'd3
    } memtoreg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline latch with the MemToReg write-data mux.
// Loads on unstalled edges, inserts a bubble while stalled, pins halt once halted.
module mem_wb_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              stall_i,
    input  logic              halted_i,
    input  logic              ex_valid_i,
    input  logic              ex_regWr_i,
    input  logic              ex_halt_i,
    input  logic [1:0]        ex_MemToReg_i,
    input  logic [4:0]        ex_wsel_i,
    input  logic [WORD_W-1:0] ex_portO_i,
    input  logic [WORD_W-1:0] ex_luiValue_i,
    input  logic [WORD_W-1:0] ex_pcp4_i,
    input  logic [WORD_W-1:0] dmemload_i,
    output logic              wb_valid_o,
    output logic              wb_regWr_o,
    output logic              wb_halt_o,
    output logic [4:0]        wb_wsel_o,
    output logic [WORD_W-1:0] wb_wdat_o
);

    logic              valid_q, regWr_q, halt_q;
    logic [4:0]        wsel_q;
    logic [WORD_W-1:0] wdat_q, wdat_d;

    always_comb begin
        wdat_d = ex_portO_i;
        case (memtoreg_t'(ex_MemToReg_i))
            MTR_ALU:  wdat_d = ex_portO_i;
            MTR_LOAD: wdat_d = dmemload_i;
            MTR_LUI:  wdat_d = ex_luiValue_i;
            MTR_PCP4: wdat_d = ex_pcp4_i;
            default:  wdat_d = ex_portO_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            regWr_q <= 1'b0;
            halt_q  <= 1'b0;
            wsel_q  <= '0;
            wdat_q  <= '0;
        end else if (halted_i) begin
            // Halt is terminal: keep signalling it, never commit another write.
            valid_q <= 1'b0;
            regWr_q <= 1'b0;
            halt_q  <= 1'b1;
        end else if (stall_i) begin
            valid_q <= 1'b0;
            regWr_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            valid_q <= ex_valid_i;
            regWr_q <= ex_regWr_i & ex_valid_i;
            halt_q  <= ex_halt_i & ex_valid_i;
            wsel_q  <= ex_wsel_i;
            wdat_q  <= wdat_d;
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_regWr_o = regWr_q;
    assign wb_halt_o  = halt_q;
    assign wb_wsel_o  = wsel_q;
    assign wb_wdat_o  = wdat_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: cache handshake FSM, stall generation and MEM/WB latch.
// Optional macro STALL_COUNTER_EN adds a saturating stall_cycles counter output.
module mem_access_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_regWr,
    input  logic [1:0]        ex_MemToReg,
    input  logic [4:0]        ex_wsel,
    input  logic              ex_halt,
    input  logic [WORD_W-1:0] ex_portO,
    input  logic [WORD_W-1:0] ex_dmemstore,
    input  logic [WORD_W-1:0] ex_luiValue,
    input  logic [WORD_W-1:0] ex_pcp4,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              mem_stall,
`ifdef STALL_COUNTER_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              wb_valid,
    output logic              wb_regWr,
    output logic              wb_halt,
    output logic [4:0]        wb_wsel,
    output logic [WORD_W-1:0] wb_wdat
);

    mem_state_t state_q, state_d;
    logic       halted, req_ok, req_any, halt_take;

    assign halted = (state_q == HALTED);
    // Reset gates the request combinationally so nothing reaches the cache mid-reset.
    assign req_ok    = nRST & ex_valid & ~halted;
    assign dmemREN   = req_ok & ex_dREN & ~ex_dWEN;
    assign dmemWEN   = req_ok & ex_dWEN;
    assign req_any   = dmemREN | dmemWEN;
    assign mem_stall = req_any & ~dhit;
    assign dmemaddr  = ex_portO;
    assign dmemstore = ex_dmemstore;
    assign halt_take = ~mem_stall & ex_valid & ex_halt & ~halted;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any && !dhit) state_d = WAIT;
            WAIT:    if (dhit) state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (halt_take) state_d = HALTED;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (!nRST)
            stall_cnt_q <= '0;
        else if (mem_stall && !halted && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cycles = stall_cnt_q;
`endif

    mem_wb_reg #(.WORD_W(WORD_W)) u_mem_wb_reg (
        .clk           (CLK),
        .nRST          (nRST),
        .stall_i       (mem_stall),
        .halted_i      (halted),
        .ex_valid_i    (ex_valid),
        .ex_regWr_i    (ex_regWr),
        .ex_halt_i     (ex_halt),
        .ex_MemToReg_i (ex_MemToReg),
        .ex_wsel_i     (ex_wsel),
        .ex_portO_i    (ex_portO),
        .ex_luiValue_i (ex_luiValue),
        .ex_pcp4_i     (ex_pcp4),
        .dmemload_i    (dmemload),
        .wb_valid_o    (wb_valid),
        .wb_regWr_o    (wb_regWr),
        .wb_halt_o     (wb_halt),
        .wb_wsel_o     (wb_wsel),
        .wb_wdat_o     (wb_wdat)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; checks stall_cycles when STALL_COUNTER_EN is defined.
module tb_mem_access_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ex_valid, ex_dREN, ex_dWEN, ex_regWr, ex_halt;
    logic [1:0]  ex_MemToReg;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_portO, ex_dmemstore, ex_luiValue, ex_pcp4;
    logic        dmemREN, dmemWEN, dhit, mem_stall;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        wb_valid, wb_regWr, wb_halt;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.WORD_W(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ex_valid     (ex_valid),
        .ex_dREN      (ex_dREN),
        .ex_dWEN      (ex_dWEN),
        .ex_regWr     (ex_regWr),
        .ex_MemToReg  (ex_MemToReg),
        .ex_wsel      (ex_wsel),
        .ex_halt      (ex_halt),
        .ex_portO     (ex_portO),
        .ex_dmemstore (ex_dmemstore),
        .ex_luiValue  (ex_luiValue),
        .ex_pcp4      (ex_pcp4),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .mem_stall    (mem_stall),
`ifdef STALL_COUNTER_EN
        .stall_cycles (stall_cycles),
`endif
        .wb_valid     (wb_valid),
        .wb_regWr     (wb_regWr),
        .wb_halt      (wb_halt),
        .wb_wsel      (wb_wsel),
        .wb_wdat      (wb_wdat)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_regWr = 0; ex_halt = 0;
        ex_MemToReg = 2'd0; ex_wsel = 5'd0;
        ex_portO = 0; ex_dmemstore = 0; ex_luiValue = 0; ex_pcp4 = 0;
        dhit = 0; dmemload = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        ex_valid = 1; ex_dREN = 1;
        #1;
        checks++;
        if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_gate: dmemREN=%b mem_stall=%b required 0 0", dmemREN, mem_stall);
        end
        tick(); tick();
        checks++;
        if ({wb_valid, wb_regWr, wb_halt} !== 3'b000 || wb_wsel !== 5'd0 || wb_wdat !== 32'd0) begin
            errors++;
            $display("FAIL reset_wb: v=%b r=%b h=%b wsel=%0d wdat=%h required all 0",
                     wb_valid, wb_regWr, wb_halt, wb_wsel, wb_wdat);
        end
        // Enter WAIT with a pending load, then reset for two edges.
        nRST = 1; ex_wsel = 5'd9; ex_regWr = 1; ex_MemToReg = 2'd1; ex_portO = 32'h80;
        tick();
        checks++;
        if (dut.state_q !== WAIT || mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_enter_wait: state=%0d stall=%b required %0d 1", dut.state_q, mem_stall, WAIT);
        end
        nRST = 0;
        tick(); tick();
        clear_inputs();
        nRST = 1; dhit = 1; dmemload = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (dmemREN !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_dhit_ren: dmemREN=%b required 0", dmemREN);
        end
        tick();
        checks++;
        if ({wb_valid, wb_regWr, wb_halt} !== 3'b000 || wb_wsel !== 5'd0 || wb_wdat !== 32'd0 ||
            dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_during_wait: v=%b r=%b h=%b wsel=%0d wdat=%h state=%0d required all 0 IDLE",
                     wb_valid, wb_regWr, wb_halt, wb_wsel, wb_wdat, dut.state_q);
        end
`ifdef STALL_COUNTER_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counter: stall_cycles=%0d required 0", stall_cycles);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_alu();
        ex_valid = 1; ex_regWr = 1; ex_MemToReg = 2'd0; ex_portO = 32'h0000_1234; ex_wsel = 5'd5;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
            errors++;
            $display("FAIL alu_nostall: stall=%b ren=%b wen=%b required 0 0 0", mem_stall, dmemREN, dmemWEN);
        end
        tick();
        checks++;
        if (wb_wdat !== 32'h1234 || wb_wsel !== 5'd5 || wb_regWr !== 1'b1 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb: wdat=%h wsel=%0d regWr=%b valid=%b required 00001234 5 1 1",
                     wb_wdat, wb_wsel, wb_regWr, wb_valid);
        end
        clear_inputs();
    endtask

    task automatic test_load();
        ex_valid = 1; ex_dREN = 1; ex_regWr = 1; ex_MemToReg = 2'd1; ex_wsel = 5'd7;
        ex_portO = 32'h0000_0200; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_stall !== 1'b1 || dmemREN !== 1'b1 || dmemaddr !== 32'h200) begin
                errors++;
                $display("FAIL load_stall_%0d: stall=%b ren=%b addr=%h required 1 1 00000200",
                         i, mem_stall, dmemREN, dmemaddr);
            end
            tick();
            checks++;
            if (wb_valid !== 1'b0 || wb_regWr !== 1'b0) begin
                errors++;
                $display("FAIL load_bubble_%0d: valid=%b regWr=%b required 0 0", i, wb_valid, wb_regWr);
            end
        end
        dhit = 1; dmemload = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_hit_stall: stall=%b required 0", mem_stall);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (wb_wdat !== 32'hDEAD_BEEF || wb_valid !== 1'b1 || wb_regWr !== 1'b1 || wb_wsel !== 5'd7 ||
            dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL load_wb: wdat=%h valid=%b regWr=%b wsel=%0d state=%0d required deadbeef 1 1 7 IDLE",
                     wb_wdat, wb_valid, wb_regWr, wb_wsel, dut.state_q);
        end
`ifdef STALL_COUNTER_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL load_counter: stall_cycles=%0d required 3", stall_cycles);
        end
`endif
    endtask

    task automatic test_store_load();
        ex_valid = 1; ex_dREN = 1; ex_dWEN = 1; ex_regWr = 0; ex_portO = 32'h40;
        ex_dmemstore = 32'h5555_AAAA; ex_wsel = 5'd3; dhit = 1;
        #1;
        checks++;
        if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || mem_stall !== 1'b0 ||
            dmemaddr !== 32'h40 || dmemstore !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL store_req: wen=%b ren=%b stall=%b addr=%h data=%h required 1 0 0 00000040 5555aaaa",
                     dmemWEN, dmemREN, mem_stall, dmemaddr, dmemstore);
        end
        tick();
        checks++;
        if (wb_regWr !== 1'b0 || wb_valid !== 1'b1 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL store_wb: regWr=%b valid=%b state=%0d required 0 1 IDLE", wb_regWr, wb_valid, dut.state_q);
        end
        clear_inputs();
    endtask

    task automatic test_memtoreg();
        ex_valid = 1; ex_regWr = 1; ex_wsel = 5'd31; ex_portO = 32'h1111_1111;
        ex_MemToReg = 2'd3; ex_pcp4 = 32'h0000_0104; ex_luiValue = 32'hABCD_0000;
        tick();
        checks++;
        if (wb_wdat !== 32'h0000_0104 || wb_wsel !== 5'd31) begin
            errors++;
            $display("FAIL mtr_pcp4: wdat=%h wsel=%0d required 00000104 31", wb_wdat, wb_wsel);
        end
        ex_MemToReg = 2'd2;
        tick();
        checks++;
        if (wb_wdat !== 32'hABCD_0000 || wb_regWr !== 1'b1) begin
            errors++;
            $display("FAIL mtr_lui: wdat=%h regWr=%b required abcd0000 1", wb_wdat, wb_regWr);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        ex_valid = 1; ex_halt = 1;
        tick();
        checks++;
        if (wb_halt !== 1'b1 || dut.state_q !== HALTED) begin
            errors++;
            $display("FAIL halt_enter: wb_halt=%b state=%0d required 1 HALTED", wb_halt, dut.state_q);
        end
        ex_halt = 0; ex_dREN = 1; ex_regWr = 1; ex_MemToReg = 2'd1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
                errors++;
                $display("FAIL halt_noreq_%0d: ren=%b stall=%b required 0 0", i, dmemREN, mem_stall);
            end
            tick();
            checks++;
            if (wb_halt !== 1'b1 || wb_regWr !== 1'b0) begin
                errors++;
                $display("FAIL halt_sticky_%0d: wb_halt=%b regWr=%b required 1 0", i, wb_halt, wb_regWr);
            end
        end
`ifdef STALL_COUNTER_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL halt_counter: stall_cycles=%0d required 3", stall_cycles);
        end
`endif
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_load();
        test_memtoreg();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
